memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  RV64 MEM stage plus MEM/WB pipeline register; sits directly upstream of writeback_stage.
//  Issues loads/stores to data memory over a req/ready handshake and stalls the pipe while waiting.
//  Aligns and sign/zero-extends load data; registers ALU/PC+4/load data and control for write-back.
//  Flags misaligned accesses and memory timeouts.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max WAIT cycles before abort with AccessFaultW (>=1)
//  CNT_W           7   width of wait counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  ValidM        in   1   instruction in MEM is real (0 = bubble)
//  RegWriteEnM   in   1   instruction writes rd
//  MemtoRegM     in   1   result comes from memory
//  JALM          in   1   result is PC+4
//  MemReadM      in   1   load
//  MemWriteM     in   1   store
//  Funct3M       in   3   access size/sign (RISC-V load/store funct3)
//  RdM           in   5   destination register
//  ALU_ResultM   in   64  effective address / ALU result
//  WriteDataM    in   64  store data (rs2)
//  PCPlus4M      in   64  PC+4 of instruction
//  dmem_req      out  1   memory request valid
//  dmem_we       out  1   1 = write
//  dmem_addr     out  64  {ALU_ResultM[63:3],3'b000}, doubleword aligned
//  dmem_wdata    out  64  store data shifted to byte lanes
//  dmem_wstrb    out  8   byte write strobes (0 on reads)
//  dmem_ready    in   1   request accepted/completed this cycle; rdata valid on reads
//  dmem_rdata    in   64  aligned doubleword read data
//  StallM        out  1   hold IF..MEM this cycle
//  RegWriteEnW, MemtoRegW, JALW  out 1 each; RdW out 5; ALU_ResultW, ReadDataW, PCPlus4W out 64
//  MisalignW     out  1   registered misaligned-access flag
//  AccessFaultW  out  1   registered timeout flag
// BEHAVIOUR
//  Reset: all *W outputs 0, state IDLE, counter 0; dmem_req and StallM forced 0 during rst.
//  mem_op = ValidM & (MemReadM|MemWriteM); MemReadM&MemWriteM both set = treat as load.
//  misaligned: H with a[0]; W with a[1:0]!=0; D with a[2:0]!=0 (a = ALU_ResultM[2:0]). Then no req.
//  dmem_req = mem_op & ~misaligned & ~rst (combinational, held stable until ready).
//  StallM = dmem_req & ~dmem_ready & ~timeout; zero-wait when ready same cycle.
//  FSM: IDLE -> WAIT when dmem_req & ~dmem_ready; WAIT -> IDLE on dmem_ready (counter cleared)
//   or when counter == TIMEOUT_CYCLES-1 (abort: req drops next cycle, AccessFaultW=1).
//  Counter increments each WAIT cycle; saturates, never wraps.
//  MEM/WB update each cycle: StallM=1 -> load bubble (RegWriteEnW=0, MemtoRegW=0, JALW=0,
//   flags 0, data regs hold). StallM=0 -> capture instruction; RegWriteEnW=RegWriteEnM&ValidM
//   &~misaligned&~fault; MisalignW/AccessFaultW as computed; ReadDataW from extend logic.
//  Store: wstrb B=1<<a, H=3<<a, W=F<<a, D=FF; wdata = WriteDataM << 8*a.
//  Load extract: lane=rdata>>8*a; 000 LB,001 LH,010 LW sign-ext; 011 LD; 100 LBU,101 LHU,110 LWU
//   zero-ext; 111 -> ReadDataW=0 and MisalignW=1.
//  Non-memory instruction: never stalls, latency 1 cycle into W registers.
//  rst in WAIT: next cycle IDLE, counter 0, no req; in-flight response ignored.
// STRUCTURE
//  Package mem_pkg: funct3 constants (F3_LB..F3_LWU), FSM state encoding (IDLE/WAIT).
//  Sub-module load_store_align (combinational): funct3+addr -> wstrb, wdata, misaligned, ext data.
//  Top: FSM, wait counter, MEM/WB register.
// TESTING
//  LD addr 0x1000, ready same cycle, rdata=0x1122334455667788 -> no stall, ReadDataW=that, MemtoRegW=1.
//  LB addr 0x1003, rdata byte3=0x80, ready after 3 cycles -> StallM 3 cycles, 3 bubbles,
//   ReadDataW=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
//  SH addr 0x2006 data 0xBEEF -> wstrb=0xC0, wdata[63:48]=0xBEEF; SW addr 0x2002 -> no req, MisalignW=1, RegWriteEnW=0.
//  Load, ready never asserted, TIMEOUT_CYCLES=4 -> StallM 4 cycles, then AccessFaultW=1, RegWriteEnW=0, req drops.
//  JAL, PCPlus4M=0x104 -> next cycle JALW=1, PCPlus4W=0x104, no dmem_req.
//  rst during WAIT -> next cycle all *W outputs 0, dmem_req=0, StallM=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RISC-V load/store funct3 encodings
// and the memory-handshake FSM state encoding.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store strobes/data placement, alignment
// check and load extraction with sign/zero extension.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] store_data,
    input  logic [63:0] load_rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic        misaligned,
    output logic [63:0] load_data
);

    logic [5:0]  shamt_s;
    logic [63:0] lane_s;

    assign shamt_s = {addr_lo, 3'b000};
    assign lane_s  = load_rdata >> shamt_s;
    assign wdata   = store_data << shamt_s;

    // Store encodings share funct3[1:0] with loads, so one decode serves both.
    always_comb begin
        wstrb      = 8'h00;
        misaligned = 1'b0;
        load_data  = 64'h0;
        case (funct3)
            F3_LB: begin
                wstrb     = 8'h01 << addr_lo;
                load_data = {{56{lane_s[7]}}, lane_s[7:0]};
            end
            F3_LH: begin
                wstrb      = 8'h03 << addr_lo;
                misaligned = addr_lo[0];
                load_data  = {{48{lane_s[15]}}, lane_s[15:0]};
            end
            F3_LW: begin
                wstrb      = 8'h0F << addr_lo;
                misaligned = (addr_lo[1:0] != 2'b00);
                load_data  = {{32{lane_s[31]}}, lane_s[31:0]};
            end
            F3_LD: begin
                wstrb      = 8'hFF;
                misaligned = (addr_lo != 3'b000);
                load_data  = lane_s;
            end
            F3_LBU: begin
                wstrb     = 8'h01 << addr_lo;
                load_data = {56'h0, lane_s[7:0]};
            end
            F3_LHU: begin
                wstrb      = 8'h03 << addr_lo;
                misaligned = addr_lo[0];
                load_data  = {48'h0, lane_s[15:0]};
            end
            F3_LWU: begin
                wstrb      = 8'h0F << addr_lo;
                misaligned = (addr_lo[1:0] != 2'b00);
                load_data  = {32'h0, lane_s[31:0]};
            end
            default: begin
                // funct3 = 111 has no legal access; reported as misaligned
                wstrb      = 8'h00;
                misaligned = 1'b1;
                load_data  = 64'h0;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// RV64 MEM stage: data-memory req/ready handshake with stall and timeout,
// load alignment, and the MEM/WB pipeline register feeding writeback_stage.
module memory_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ValidM,
    input  logic        RegWriteEnM,
    input  logic        MemtoRegM,
    input  logic        JALM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RdM,
    input  logic [63:0] ALU_ResultM,
    input  logic [63:0] WriteDataM,
    input  logic [63:0] PCPlus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteEnW,
    output logic        MemtoRegW,
    output logic        JALW,
    output logic [4:0]  RdW,
    output logic [63:0] ALU_ResultW,
    output logic [63:0] ReadDataW,
    output logic [63:0] PCPlus4W,
    output logic        MisalignW,
    output logic        AccessFaultW
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_op_s, misaligned_s, align_mis_s, timeout_s;
    logic [7:0]  wstrb_s;
    logic [63:0] wdata_s, ext_s;

    logic        reg_write_en_w_q, reg_write_en_w_d;
    logic        memto_reg_w_q, memto_reg_w_d;
    logic        jal_w_q, jal_w_d;
    logic        misalign_w_q, misalign_w_d;
    logic        access_fault_w_q, access_fault_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [63:0] alu_result_w_q, alu_result_w_d;
    logic [63:0] read_data_w_q, read_data_w_d;
    logic [63:0] pc_plus4_w_q, pc_plus4_w_d;

    load_store_align u_align (
        .funct3     (Funct3M),
        .addr_lo    (ALU_ResultM[2:0]),
        .store_data (WriteDataM),
        .load_rdata (dmem_rdata),
        .wstrb      (wstrb_s),
        .wdata      (wdata_s),
        .misaligned (align_mis_s),
        .load_data  (ext_s)
    );

    // Memory request and stall; a load+store combination is handled as a load.
    always_comb begin
        mem_op_s     = ValidM & (MemReadM | MemWriteM);
        misaligned_s = mem_op_s & align_mis_s;
        dmem_req     = mem_op_s & ~misaligned_s & ~rst;
        dmem_we      = dmem_req & ~MemReadM;
        dmem_wstrb   = dmem_we ? wstrb_s : 8'h00;
        dmem_wdata   = wdata_s;
        dmem_addr    = {ALU_ResultM[63:3], 3'b000};
        timeout_s    = (state_q == WAIT) & dmem_req & ~dmem_ready & (cnt_q == CNT_LAST);
        StallM       = dmem_req & ~dmem_ready & ~timeout_s;
    end

    // Handshake FSM and saturating wait counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (dmem_req & ~dmem_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (~dmem_req | dmem_ready | timeout_s) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = WAIT;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // MEM/WB register: a stalled cycle inserts a bubble and holds the data fields.
    always_comb begin
        rd_w_d         = rd_w_q;
        alu_result_w_d = alu_result_w_q;
        read_data_w_d  = read_data_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        if (StallM) begin
            reg_write_en_w_d = 1'b0;
            memto_reg_w_d    = 1'b0;
            jal_w_d          = 1'b0;
            misalign_w_d     = 1'b0;
            access_fault_w_d = 1'b0;
        end else begin
            reg_write_en_w_d = RegWriteEnM & ValidM & ~misaligned_s & ~timeout_s;
            memto_reg_w_d    = MemtoRegM & ValidM;
            jal_w_d          = JALM & ValidM;
            misalign_w_d     = misaligned_s;
            access_fault_w_d = timeout_s;
            rd_w_d           = RdM;
            alu_result_w_d   = ALU_ResultM;
            read_data_w_d    = ext_s;
            pc_plus4_w_d     = PCPlus4M;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= {CNT_W{1'b0}};
            reg_write_en_w_q <= 1'b0;
            memto_reg_w_q    <= 1'b0;
            jal_w_q          <= 1'b0;
            misalign_w_q     <= 1'b0;
            access_fault_w_q <= 1'b0;
            rd_w_q           <= 5'd0;
            alu_result_w_q   <= 64'h0;
            read_data_w_q    <= 64'h0;
            pc_plus4_w_q     <= 64'h0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            reg_write_en_w_q <= reg_write_en_w_d;
            memto_reg_w_q    <= memto_reg_w_d;
            jal_w_q          <= jal_w_d;
            misalign_w_q     <= misalign_w_d;
            access_fault_w_q <= access_fault_w_d;
            rd_w_q           <= rd_w_d;
            alu_result_w_q   <= alu_result_w_d;
            read_data_w_q    <= read_data_w_d;
            pc_plus4_w_q     <= pc_plus4_w_d;
        end
    end

    assign RegWriteEnW  = reg_write_en_w_q;
    assign MemtoRegW    = memto_reg_w_q;
    assign JALW         = jal_w_q;
    assign MisalignW    = misalign_w_q;
    assign AccessFaultW = access_fault_w_q;
    assign RdW          = rd_w_q;
    assign ALU_ResultW  = alu_result_w_q;
    assign ReadDataW    = read_data_w_q;
    assign PCPlus4W     = pc_plus4_w_q;

endmodule
